pipeline_control: RTL and testbench

- Central stall/flush controller. It produces the 6-bit stall vector that every inter-stage pipeline register (pc, if_id, id_ex, ex_mem, mem_wb) consumes.
- It arbitrates stall requests from the IF, ID, EX and MEM stages into a single stall vector.
- It sequences a one-cycle pipeline flush with a redirect PC on exception.
- It tracks stall statistics and raises a sticky timeout when the pipeline stays frozen too long.

---
 rtl/pipeline_control_pkg.sv | 38 +++
 rtl/pipeline_control_sat_counter.sv | 24 ++
 rtl/pipeline_control.sv | 95 +++++++++
 tb/tb_pipeline_control.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Stall vector bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
package pipeline_control_pkg;

  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_FROM_IF  = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_FROM_ID  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_FROM_EX  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_FROM_MEM = 6'b011111;

  typedef enum logic {
    PCTRL_RUN   = 1'b0,
    PCTRL_FLUSH = 1'b1
  } pctrl_state_e;

  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
    logic fetch;
  } stall_req_t;

  // The furthest-downstream requester freezes itself and everything upstream;
  // the stage just after it keeps running and so receives a bubble.
  function automatic logic [STALL_W-1:0] stall_select(input stall_req_t req);
    if (req.mem == STALL_ENABLE)        return STALL_FROM_MEM;
    else if (req.ex == STALL_ENABLE)    return STALL_FROM_EX;
    else if (req.id == STALL_ENABLE)    return STALL_FROM_ID;
    else if (req.fetch == STALL_ENABLE) return STALL_FROM_IF;
    else                                return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush controller: arbitrates stage stall requests, sequences
// single-cycle flushes with a redirect PC, and tracks stall statistics.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RUN_WIDTH      = 8,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall_request_if,
  input  logic                   stall_request_id,
  input  logic                   stall_request_ex,
  input  logic                   stall_request_mem,
  input  logic                   flush_request,
  input  logic [31:0]            flush_target_pc,
  output logic [STALL_W-1:0]     stall,
  output logic                   flush,
  output logic [31:0]            new_pc,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] stall_cycle_count
);

  localparam logic [RUN_WIDTH-1:0] RUN_MAX = RUN_WIDTH'(TIMEOUT_CYCLES);

  pctrl_state_e         state;
  stall_req_t           req;
  logic                 stalled;
  logic                 run_hit;
  logic [RUN_WIDTH-1:0] run_count;

  assign req = '{mem:   stall_request_mem,
                 ex:    stall_request_ex,
                 id:    stall_request_id,
                 fetch: stall_request_if};

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    stall = STALL_NONE;
    if (reset && (state == PCTRL_RUN)) begin
      stall = stall_select(req);
    end
  end

  assign stalled = |stall;

  // The run counter lands on RUN_MAX at this edge.
  assign run_hit = stalled && (run_count >= (RUN_MAX - RUN_WIDTH'(1)));

  // A flush cycle forces stall to zero, so clearing on !stalled also covers FLUSH.
  sat_counter #(.WIDTH(RUN_WIDTH)) u_run_counter (
    .clock (clock),
    .reset (reset),
    .inc   (stalled && (run_count != RUN_MAX)),
    .clr   (!stalled),
    .value (run_count)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_total_counter (
    .clock (clock),
    .reset (reset),
    .inc   (stalled),
    .clr   (1'b0),
    .value (stall_cycle_count)
  );

  // A sampled flush_request always lands in FLUSH, whether coming from RUN or
  // re-arming an ongoing flush, and always recaptures the redirect target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= PCTRL_RUN;
      flush   <= 1'b0;
      new_pc  <= '0;
      timeout <= 1'b0;
    end else begin
      if (flush_request) begin
        state  <= PCTRL_FLUSH;
        flush  <= 1'b1;
        new_pc <= flush_target_pc;
      end else begin
        state <= PCTRL_RUN;
        flush <= 1'b0;
      end

      if (flush_request) begin
        timeout <= 1'b0;
      end else if (run_hit) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: table-driven vectors plus hand-written
// multi-cycle sequences for timeout, clear-over-set, reset and saturation.
module tb_pipeline_control;

  localparam int CW = 3;

  logic          clock;
  logic          reset;
  logic          req_if, req_id, req_ex, req_mem;
  logic          flush_request;
  logic [31:0]   flush_target_pc;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic          timeout;
  logic [CW-1:0] stall_cycle_count;

  int total = 0;
  int bad   = 0;

  pipeline_control #(
    .TIMEOUT_CYCLES (4),
    .RUN_WIDTH      (8),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .stall_request_if  (req_if),
    .stall_request_id  (req_id),
    .stall_request_ex  (req_ex),
    .stall_request_mem (req_mem),
    .flush_request     (flush_request),
    .flush_target_pc   (flush_target_pc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .timeout           (timeout),
    .stall_cycle_count (stall_cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          mem, ex, id, fetch, freq;
    logic [31:0]   pc;
    logic [5:0]    e_stall;
    logic          e_flush;
    logic [31:0]   e_pc;
    logic          e_to;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mem, ex, id, fetch, freq, input logic [31:0] pc);
    req_mem = mem; req_ex = ex; req_id = id; req_if = fetch;
    flush_request = freq; flush_target_pc = pc;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    // Each row: inputs applied after a falling edge; the registered outputs and
    // count reflect edges before this row, stall reflects this row's inputs.
    //            mem ex id if fr  pc           stall      fl pc          to cnt
    vecs[0]  = '{1, 0, 1, 0, 0, 32'h0,   6'b011111, 0, 32'h0,   0, 3'd0};
    vecs[1]  = '{0, 0, 1, 0, 0, 32'h0,   6'b000111, 0, 32'h0,   0, 3'd1};
    vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 3'd2};
    vecs[3]  = '{0, 0, 0, 1, 0, 32'h0,   6'b000011, 0, 32'h0,   0, 3'd2};
    vecs[4]  = '{0, 1, 1, 1, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 3'd3};
    vecs[5]  = '{0, 1, 0, 0, 1, 32'h180, 6'b001111, 0, 32'h0,   0, 3'd4};
    vecs[6]  = '{0, 1, 0, 0, 0, 32'h0,   6'b000000, 1, 32'h180, 0, 3'd5};
    vecs[7]  = '{0, 1, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h180, 0, 3'd5};
    vecs[8]  = '{0, 0, 0, 0, 1, 32'h100, 6'b000000, 0, 32'h180, 0, 3'd6};
    vecs[9]  = '{0, 0, 0, 1, 1, 32'h200, 6'b000000, 1, 32'h100, 0, 3'd6};
    vecs[10] = '{0, 0, 0, 0, 0, 32'h0,   6'b000000, 1, 32'h200, 0, 3'd6};
    vecs[11] = '{0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h200, 0, 3'd6};

    // Reset held with every request asserted.
    reset = 1'b0;
    drive(1, 1, 1, 1, 1, 32'hDEAD_BEEF);
    repeat (2) @(negedge clock);
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_pc", new_pc, 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_count", 32'(stall_cycle_count), 32'h0);

    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, 1, 0, 0, 32'h0);
    #1;
    check("release_id_stall", 32'(stall), 32'h07);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].mem, vecs[i].ex, vecs[i].id, vecs[i].fetch, vecs[i].freq, vecs[i].pc);
      #1;
      check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      check($sformatf("v%0d_pc", i), new_pc, vecs[i].e_pc);
      check($sformatf("v%0d_timeout", i), 32'(timeout), 32'(vecs[i].e_to));
      check($sformatf("v%0d_count", i), 32'(stall_cycle_count), 32'(vecs[i].e_cnt));
      @(negedge clock);
    end

    // Asynchronous reset in the middle of a flush.
    drive(0, 1, 0, 0, 1, 32'h300);
    @(negedge clock);
    drive(0, 1, 0, 0, 0, 32'h0);
    #1;
    check("midflush_pre_flush", 32'(flush), 32'h1);
    check("midflush_pre_pc", new_pc, 32'h300);
    reset = 1'b0;
    #1;
    check("midflush_rst_flush", 32'(flush), 32'h0);
    check("midflush_rst_pc", new_pc, 32'h0);
    check("midflush_rst_stall", 32'(stall), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0);

    // Timeout after the 4th consecutive stalled edge, sticky until a flush.
    do_reset();
    drive(1, 0, 0, 0, 0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      #1;
      check($sformatf("to_edge%0d", k), 32'(timeout), (k == 4) ? 32'h1 : 32'h0);
      check($sformatf("to_count%0d", k), 32'(stall_cycle_count), 32'(k));
    end
    drive(0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(negedge clock);
    #1;
    check("to_sticky", 32'(timeout), 32'h1);
    check("to_sticky_stall", 32'(stall), 32'h0);
    drive(0, 0, 0, 0, 1, 32'h40);
    @(posedge clock);
    #1;
    check("to_clear", 32'(timeout), 32'h0);
    check("to_clear_flush", 32'(flush), 32'h1);
    drive(0, 0, 0, 0, 0, 32'h0);
    @(negedge clock);

    // Clear wins over set, with the total counter saturating at 7 on the way.
    drive(0, 1, 0, 0, 0, 32'h0);
    #1;
    check("cw_flush_stall", 32'(stall), 32'h0);
    @(negedge clock);
    #1;
    check("cw_run_stall", 32'(stall), 32'h0F);
    repeat (3) @(negedge clock);
    drive(0, 1, 0, 0, 1, 32'h80);
    @(negedge clock);
    #1;
    check("cw_timeout", 32'(timeout), 32'h0);
    check("cw_flush", 32'(flush), 32'h1);
    check("cw_count_sat", 32'(stall_cycle_count), 32'h7);
    drive(0, 0, 0, 0, 0, 32'h0);

    // Saturation from a clean start: 1..7 then hold.
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      #1;
      check($sformatf("sat_%0d", k), 32'(stall_cycle_count), (k > 7) ? 32'h7 : 32'(k));
    end
    drive(0, 0, 0, 0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
